// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode CSR file: address map, op encodings,
// mstatus/mie bit positions and reset constants.
package csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_RW   = 2'b01,
        OP_RS   = 2'b10,
        OP_RC   = 2'b11
    } csrOpE;

    localparam int unsigned MSTATUS_MIE  = 3;
    localparam int unsigned MSTATUS_MPIE = 7;
    localparam int unsigned MEIE_BIT     = 11;

    localparam logic [31:0] MSTATUS_RESET = 32'h0000_1800;

    // Read-modify-write; an unused op encoding leaves the value unchanged.
    function automatic logic [31:0] applyOp(input csrOpE op, input logic [31:0] oldVal,
                                            input logic [31:0] src, input logic invSrc);
        logic [31:0] res;
        res = oldVal;
        case (op)
            OP_RW:   res = src;
            OP_RS:   res = oldVal | src;
            OP_RC:   res = oldVal & (invSrc ? ~src : src);
            default: res = oldVal;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/csr_counter64.sv
// 64-bit counter with increment enable and independent low/high word writes.
// A low-word write suppresses the carry into the high word for that cycle.
module csr_counter64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        incEn,
    input  logic        wrLo,
    input  logic        wrHi,
    input  logic [31:0] wrData,
    output logic [63:0] count
);

    logic [31:0] lo;
    logic [31:0] hi;
    logic        carry;

    assign carry = incEn & (lo == '1) & ~wrLo;
    assign count = {hi, lo};

    always_ff @(posedge clk) begin
        if (rst) begin
            lo <= '0;
            hi <= '0;
        end else begin
            lo <= wrLo ? wrData : lo + {31'd0, incEn};
            hi <= wrHi ? wrData : hi + {31'd0, carry};
        end
    end

endmodule

// File: rtl/csr_file.sv
// Machine-mode CSR file for the RV32I core: CSR read-modify-write, trap/mret
// state updates, 64-bit cycle/instret counters and interrupt gating.
module csr_file
    import csr_pkg::*;
#(
    parameter logic [31:0] HART_ID  = 32'd0,
    parameter logic [31:0] MISA_VAL = 32'h4000_0100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        csrValid,
    input  logic [11:0] csrAddr,
    input  logic [1:0]  csrOp,
    input  logic        csrWrite,
    input  logic        csrRead,
    input  logic        invRs1,
    input  logic        useImm,
    input  logic [31:0] csrImm,
    input  logic [31:0] rs1Data,
    output logic [31:0] csrRdata,
    output logic        csrIllegal,
    input  logic        instrRetire,
    input  logic        trapValid,
    input  logic [31:0] trapCause,
    input  logic [31:0] trapPc,
    input  logic [31:0] trapVal,
    input  logic        mretValid,
    output logic [31:0] trapVector,
    output logic [31:0] mepcOut,
    input  logic        extIrq,
    output logic        irqPending
);

    logic        mstatusMie;
    logic        mstatusMpie;
    logic        mieMeie;
    logic [31:0] mtvec;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [63:0] cycleCnt;
    logic [63:0] instretCnt;

    logic [31:0] mstatusVal;
    logic [31:0] oldVal;
    logic [31:0] newVal;
    logic [31:0] src;
    logic        mapped;
    logic        wrEn;

    assign mstatusVal = {19'd0, 2'b11, 3'd0, mstatusMpie, 3'd0, mstatusMie, 3'd0};

    always_comb begin
        mapped = 1'b1;
        oldVal = '0;
        case (csrAddr)
            ADDR_MSTATUS:                 oldVal = mstatusVal;
            ADDR_MISA:                    oldVal = MISA_VAL;
            ADDR_MIE:                     oldVal = {20'd0, mieMeie, 11'd0};
            ADDR_MTVEC:                   oldVal = mtvec;
            ADDR_MSCRATCH:                oldVal = mscratch;
            ADDR_MEPC:                    oldVal = mepc;
            ADDR_MCAUSE:                  oldVal = mcause;
            ADDR_MTVAL:                   oldVal = mtval;
            ADDR_MIP:                     oldVal = {20'd0, extIrq, 11'd0};
            ADDR_MCYCLE, ADDR_CYCLE:      oldVal = cycleCnt[31:0];
            ADDR_MCYCLEH, ADDR_CYCLEH:    oldVal = cycleCnt[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:  oldVal = instretCnt[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: oldVal = instretCnt[63:32];
            ADDR_MHARTID:                 oldVal = HART_ID;
            default:                      mapped = 1'b0;
        endcase
    end

    assign csrIllegal = csrValid & (~mapped | (csrWrite & (csrAddr[11:10] == 2'b11)));
    assign csrRdata   = (csrValid & csrRead & ~csrIllegal) ? oldVal : '0;
    assign src        = useImm ? csrImm : rs1Data;
    assign newVal     = applyOp(csrOpE'(csrOp), oldVal, src, invRs1);
    assign wrEn       = csrValid & csrWrite & ~csrIllegal & ~trapValid;

    assign trapVector = {mtvec[31:2], 2'b00};
    assign mepcOut    = mepc;
    assign irqPending = mstatusMie & mieMeie & extIrq;

    // Later assignments win: mret overrides a same-cycle mstatus write,
    // and trap entry blocks both writes and mret entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatusMie  <= MSTATUS_RESET[MSTATUS_MIE];
            mstatusMpie <= MSTATUS_RESET[MSTATUS_MPIE];
            mieMeie     <= 1'b0;
            mtvec       <= '0;
            mscratch    <= '0;
            mepc        <= '0;
            mcause      <= '0;
            mtval       <= '0;
        end else if (trapValid) begin
            mepc        <= trapPc & ~32'd3;
            mcause      <= trapCause;
            mtval       <= trapVal;
            mstatusMpie <= mstatusMie;
            mstatusMie  <= 1'b0;
        end else begin
            if (wrEn) begin
                case (csrAddr)
                    ADDR_MSTATUS: begin
                        mstatusMie  <= newVal[MSTATUS_MIE];
                        mstatusMpie <= newVal[MSTATUS_MPIE];
                    end
                    ADDR_MIE:      mieMeie  <= newVal[MEIE_BIT];
                    ADDR_MTVEC:    mtvec    <= newVal & ~32'd3;
                    ADDR_MSCRATCH: mscratch <= newVal;
                    ADDR_MEPC:     mepc     <= newVal & ~32'd3;
                    ADDR_MCAUSE:   mcause   <= newVal;
                    ADDR_MTVAL:    mtval    <= newVal;
                    default: ;
                endcase
            end
            if (mretValid) begin
                mstatusMie  <= mstatusMpie;
                mstatusMpie <= 1'b1;
            end
        end
    end

    csr_counter64 uCycle (
        .clk   (clk),
        .rst   (rst),
        .incEn (1'b1),
        .wrLo  (wrEn & (csrAddr == ADDR_MCYCLE)),
        .wrHi  (wrEn & (csrAddr == ADDR_MCYCLEH)),
        .wrData(newVal),
        .count (cycleCnt)
    );

    csr_counter64 uInstret (
        .clk   (clk),
        .rst   (rst),
        .incEn (instrRetire),
        .wrLo  (wrEn & (csrAddr == ADDR_MINSTRET)),
        .wrHi  (wrEn & (csrAddr == ADDR_MINSTRETH)),
        .wrData(newVal),
        .count (instretCnt)
    );

endmodule

// File: tb/tb_csr_file.sv
// Self-checking bench for csr_file: directed scenarios plus randomized traffic,
// compared every cycle against an architectural model of the CSR state.
module tb_csr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        csrValid;
    logic [11:0] csrAddr;
    logic [1:0]  csrOp;
    logic        csrWrite;
    logic        csrRead;
    logic        invRs1;
    logic        useImm;
    logic [31:0] csrImm;
    logic [31:0] rs1Data;
    logic [31:0] csrRdata;
    logic        csrIllegal;
    logic        instrRetire;
    logic        trapValid;
    logic [31:0] trapCause;
    logic [31:0] trapPc;
    logic [31:0] trapVal;
    logic        mretValid;
    logic [31:0] trapVector;
    logic [31:0] mepcOut;
    logic        extIrq;
    logic        irqPending;

    int total = 0;
    int bad   = 0;

    // architectural model state
    logic [31:0] mMstatus, mMie, mMtvec, mMscratch, mMepc, mMcause, mMtval;
    logic [63:0] mCyc, mIns;

    // outputs sampled during the most recent cycle
    logic [31:0] sRdata;
    logic        sIll, sIrq;

    logic [11:0] addrList [0:21];

    csr_file #(.HART_ID(32'd0), .MISA_VAL(32'h4000_0100)) dut (
        .clk(clk), .rst(rst), .csrValid(csrValid), .csrAddr(csrAddr), .csrOp(csrOp),
        .csrWrite(csrWrite), .csrRead(csrRead), .invRs1(invRs1), .useImm(useImm),
        .csrImm(csrImm), .rs1Data(rs1Data), .csrRdata(csrRdata), .csrIllegal(csrIllegal),
        .instrRetire(instrRetire), .trapValid(trapValid), .trapCause(trapCause),
        .trapPc(trapPc), .trapVal(trapVal), .mretValid(mretValid), .trapVector(trapVector),
        .mepcOut(mepcOut), .extIrq(extIrq), .irqPending(irqPending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mRead(input logic [11:0] a, output bit ok);
        ok = 1'b1;
        case (a)
            12'h300: return mMstatus;
            12'h301: return 32'h4000_0100;
            12'h304: return mMie;
            12'h305: return mMtvec;
            12'h340: return mMscratch;
            12'h341: return mMepc;
            12'h342: return mMcause;
            12'h343: return mMtval;
            12'h344: return extIrq ? 32'h800 : 32'h0;
            12'hB00, 12'hC00: return mCyc[31:0];
            12'hB80, 12'hC80: return mCyc[63:32];
            12'hB02, 12'hC02: return mIns[31:0];
            12'hB82, 12'hC82: return mIns[63:32];
            12'hF14: return 32'd0;
            default: begin ok = 1'b0; return 32'd0; end
        endcase
    endfunction

    task automatic modelReset();
        mMstatus = 32'h1800;
        mMie = 0; mMtvec = 0; mMscratch = 0; mMepc = 0; mMcause = 0; mMtval = 0;
        mCyc = 0; mIns = 0;
    endtask

    task automatic idle();
        csrValid = 0; csrAddr = 0; csrOp = 0; csrWrite = 0; csrRead = 0;
        invRs1 = 0; useImm = 0; csrImm = 0; rs1Data = 0;
        trapValid = 0; trapCause = 0; trapPc = 0; trapVal = 0; mretValid = 0;
        rst = 0;
    endtask

    // One clock: check combinational outputs against the model, then advance it.
    task automatic cycle();
        bit ok, ill, wr;
        logic [31:0] old, src, nv, expRd, om;
        logic [63:0] nc, ni;
        #1;
        old   = mRead(csrAddr, ok);
        ill   = csrValid && (!ok || (csrWrite && csrAddr[11:10] == 2'b11));
        expRd = (csrValid && csrRead && !ill) ? old : 32'd0;
        chk("rdata", csrRdata, expRd);
        chk("illegal", {31'd0, csrIllegal}, {31'd0, ill});
        chk("trapVector", trapVector, mMtvec);
        chk("mepcOut", mepcOut, mMepc);
        chk("irqPending", {31'd0, irqPending}, {31'd0, mMstatus[3] & mMie[11] & extIrq});
        sRdata = csrRdata; sIll = csrIllegal; sIrq = irqPending;
        @(posedge clk);
        if (rst) begin
            modelReset();
        end else begin
            src = useImm ? csrImm : rs1Data;
            case (csrOp)
                2'b01:   nv = src;
                2'b10:   nv = old | src;
                2'b11:   nv = invRs1 ? (old & ~src) : (old & src);
                default: nv = old;
            endcase
            wr = csrValid && csrWrite && !ill && !trapValid;
            nc = mCyc + 64'd1;
            if (wr && csrAddr == 12'hB00) nc = {mCyc[63:32], nv};
            if (wr && csrAddr == 12'hB80) nc[63:32] = nv;
            ni = mIns + (instrRetire ? 64'd1 : 64'd0);
            if (wr && csrAddr == 12'hB02) ni = {mIns[63:32], nv};
            if (wr && csrAddr == 12'hB82) ni[63:32] = nv;
            mCyc = nc; mIns = ni;
            om = mMstatus;
            if (trapValid) begin
                mMepc = trapPc & ~32'd3; mMcause = trapCause; mMtval = trapVal;
                mMstatus = 32'h1800 | (om[3] ? 32'h80 : 32'h0);
            end else begin
                if (wr) begin
                    case (csrAddr)
                        12'h300: mMstatus  = (nv & 32'h88) | 32'h1800;
                        12'h304: mMie      = nv & 32'h800;
                        12'h305: mMtvec    = nv & ~32'd3;
                        12'h340: mMscratch = nv;
                        12'h341: mMepc     = nv & ~32'd3;
                        12'h342: mMcause   = nv;
                        12'h343: mMtval    = nv;
                        default: ;
                    endcase
                end
                if (mretValid) mMstatus = 32'h1880 | (om[7] ? 32'h8 : 32'h0);
            end
        end
        @(negedge clk);
        idle();
    endtask

    task automatic csr(input logic [11:0] a, input logic [1:0] op, input logic wr,
                       input logic rd, input logic inv, input logic imm, input logic [31:0] val);
        csrValid = 1; csrAddr = a; csrOp = op; csrWrite = wr; csrRead = rd;
        invRs1 = inv; useImm = imm;
        if (imm) csrImm = val; else rs1Data = val;
        cycle();
    endtask

    task automatic rdCsr(input logic [11:0] a);
        csr(a, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    endtask

    initial begin
        addrList = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                     12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC02, 12'hC80,
                     12'hC82, 12'hF14, 12'h7C0, 12'h345, 12'h000, 12'hB01};
        idle();
        extIrq = 0; instrRetire = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        modelReset();
        @(negedge clk);
        rst = 0;

        // reset state
        rdCsr(12'h300);
        chk("resetMstatus", sRdata, 32'h1800);
        rdCsr(12'hB80);
        chk("resetMcycleh", sRdata, 32'h0);

        // mscratch write and read-modify ops
        csr(12'h340, 2'b01, 1, 1, 0, 0, 32'hDEADBEEF);
        chk("mscratchFirstOld", sRdata, 32'h0);
        rdCsr(12'h340);
        chk("mscratchRw", sRdata, 32'hDEADBEEF);
        csr(12'h340, 2'b10, 1, 1, 0, 0, 32'hF);
        chk("mscratchRsOld", sRdata, 32'hDEADBEEF);
        csr(12'h340, 2'b11, 1, 1, 1, 1, 32'h1F);
        rdCsr(12'h340);
        chk("mscratchRc", sRdata, 32'hDEADBEE0);

        // WARL on mtvec / mepc
        csr(12'h305, 2'b01, 1, 0, 0, 0, 32'h80000103);
        rdCsr(12'h305);
        chk("mtvecWarl", sRdata, 32'h80000100);
        chk("trapVectorWarl", trapVector, 32'h80000100);
        csr(12'h341, 2'b01, 1, 0, 0, 0, 32'h3);
        rdCsr(12'h341);
        chk("mepcWarl", sRdata, 32'h0);

        // counter carry, then high-half write beating the carry
        csr(12'hB00, 2'b01, 1, 0, 0, 0, 32'hFFFFFFFE);
        cycle(); cycle();
        rdCsr(12'hB80);
        chk("mcyclehCarry", sRdata, 32'h1);
        csr(12'hB00, 2'b01, 1, 0, 0, 0, 32'hFFFFFFFE);
        cycle();
        csr(12'hB80, 2'b01, 1, 0, 0, 0, 32'h5);
        rdCsr(12'hB80);
        chk("mcyclehOverride", sRdata, 32'h5);

        // trap entry dropping a concurrent write, then mret
        csr(12'h300, 2'b10, 1, 0, 0, 0, 32'h8);
        trapValid = 1; trapCause = 32'h8000000B; trapPc = 32'h1006; trapVal = 32'h55;
        csr(12'h340, 2'b01, 1, 0, 0, 0, 32'h12345678);
        rdCsr(12'h341);
        chk("trapMepc", sRdata, 32'h1004);
        rdCsr(12'h300);
        chk("trapMstatus", sRdata, 32'h1880);
        rdCsr(12'h340);
        chk("trapDropsWrite", sRdata, 32'hDEADBEE0);
        rdCsr(12'h342);
        chk("trapMcause", sRdata, 32'h8000000B);
        mretValid = 1;
        cycle();
        rdCsr(12'h300);
        chk("mretMstatus", sRdata, 32'h1888);
        chk("mretMepcOut", mepcOut, 32'h1004);

        // illegal accesses
        csr(12'hC00, 2'b01, 1, 0, 0, 0, 32'h77);
        chk("illegalRoWrite", {31'd0, sIll}, 32'h1);
        csr(12'h7C0, 2'b01, 1, 1, 0, 0, 32'h77);
        chk("illegalUnmapped", {31'd0, sIll}, 32'h1);
        chk("illegalRdata", sRdata, 32'h0);

        // interrupt gating and mid-run reset
        csr(12'h304, 2'b01, 1, 0, 0, 0, 32'hFFFFFFFF);
        extIrq = 1;
        cycle();
        chk("irqPendingSet", {31'd0, sIrq}, 32'h1);
        rst = 1;
        cycle();
        rdCsr(12'h300);
        chk("midResetMstatus", sRdata, 32'h1800);
        chk("midResetIrq", {31'd0, sIrq}, 32'h0);
        rdCsr(12'hB02);
        chk("midResetMinstret", sRdata, 32'h0);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            extIrq = 1'($urandom_range(0, 1));
            instrRetire = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) != 0) begin
                csrValid = 1;
                csrAddr  = addrList[$urandom_range(0, 21)];
                csrOp    = 2'($urandom_range(1, 3));
                csrWrite = 1'($urandom_range(0, 1));
                csrRead  = (csrWrite && csrAddr[11:10] == 2'b11) ? 1'b0 : 1'($urandom_range(0, 1));
                invRs1   = 1'($urandom_range(0, 1));
                useImm   = 1'($urandom_range(0, 1));
                csrImm   = $urandom_range(0, 31);
                rs1Data  = (i % 7 == 0) ? 32'hFFFFFFFF : $urandom;
            end
            if ($urandom_range(0, 15) == 0) begin
                trapValid = 1; trapCause = $urandom; trapPc = $urandom; trapVal = $urandom;
            end
            if ($urandom_range(0, 11) == 0) mretValid = 1;
            if ($urandom_range(0, 99) == 0) rst = 1;
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
